control_sequencer: RTL and testbench

Multicycle control unit state register and sequencer for the MIPS datapath. It steps each instruction through fetch, decode and execute states, and takes its decode-time next state from the instruction encoder's 7-bit `State_Sel`. In every state it drives the Moore control word for the datapath, and it performs the memory handshake (`MOV`/`MOC`).

---
 rtl/control_pkg.sv | 65 ++++++
 rtl/control_rom.sv | 72 +++++++
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t      : sequencer state encodings (7-bit, matches Current_State)
//   - ALU_* codes  : 4-bit ALU function selects driven on ALU_Op
//   - ctrl_word_t  : Moore control word produced for every state
//   - is_decodable : true for the State_Sel values the decode state accepts
// Optional feature macro used by the importing files: SEQ_MOC_TIMEOUT_EN
// -----------------------------------------------------------------------------
package control_pkg;

   typedef enum logic [6:0] {
      S_RESET      = 7'd0,
      S_FETCH_ADDR = 7'd1,
      S_FETCH_WAIT = 7'd2,
      S_IR_LOAD    = 7'd3,
      S_DECODE     = 7'd4,
      S_BUS_ERR    = 7'd5,
      S_ADDU       = 7'd6,
      S_ST_ADDR    = 7'd7,
      S_ST_DATA    = 7'd8,
      S_ST_WAIT    = 7'd9,
      S_ILLEGAL    = 7'd10,
      S_BEQ        = 7'd11,
      S_BR_TAKEN   = 7'd12,
      S_LD_ADDR    = 7'd13,
      S_LD_WAIT    = 7'd14,
      S_LD_WB      = 7'd15,
      S_SUBU       = 7'd17,
      S_ADDIU      = 7'd18,
      S_SLTU       = 7'd19
   } state_t;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLTU   = 4'd2;
   localparam logic [3:0] ALU_PASS_B = 4'd3;

   typedef struct packed {
      logic       mar_ld;
      logic       ir_ld;
      logic       pc_ld;
      logic       npc_ld;
      logic       rf_ld;
      logic       mdr_ld;
      logic       mov;
      logic       rw;
      logic [3:0] alu_op;
      logic       illegal_instr;
      logic       bus_err;
   } ctrl_word_t;

   // Only these encoder outputs name a real execute state; anything else
   // is routed to the illegal-instruction state by the decode step.
   function automatic logic is_decodable(input logic [6:0] sel);
      logic ok;
      ok = 1'b0;
      case (sel)
         S_ADDU, S_ST_ADDR, S_BEQ, S_LD_ADDR, S_SUBU, S_ADDIU, S_SLTU: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/control_rom.sv
// -----------------------------------------------------------------------------
// control_rom
// Combinational state-to-control-word decode (Moore outputs of the sequencer).
// Ports:
//   state : current sequencer state (7-bit)
//   cw    : control word for the datapath in that state
// Optional feature macro: SEQ_MOC_TIMEOUT_EN (enables the bus-error state
// output; without it the bus_err field is always 0).
// -----------------------------------------------------------------------------
module control_rom
   import control_pkg::*;
   (
   input  logic [6:0] state,
   output ctrl_word_t cw
   );

   // Start from the idle word (no loads, read direction, ADD) and set only
   // the fields each state needs; the reset state clears everything,
   // including the read/write direction.
   always_comb begin
      cw        = '0;
      cw.rw     = 1'b1;
      cw.alu_op = ALU_ADD;
      case (state)
         S_RESET:      cw = '0;
         S_FETCH_ADDR: cw.mar_ld = 1'b1;
         S_FETCH_WAIT: cw.mov = 1'b1;
         S_IR_LOAD: begin
            cw.ir_ld  = 1'b1;
            cw.pc_ld  = 1'b1;
            cw.npc_ld = 1'b1;
         end
         S_DECODE:     ;
         S_ADDU:       cw.rf_ld = 1'b1;
         S_SUBU: begin
            cw.rf_ld  = 1'b1;
            cw.alu_op = ALU_SUB;
         end
         S_ADDIU:      cw.rf_ld = 1'b1;
         S_SLTU: begin
            cw.rf_ld  = 1'b1;
            cw.alu_op = ALU_SLTU;
         end
         S_ST_ADDR:    cw.mar_ld = 1'b1;
         S_ST_DATA:    cw.mdr_ld = 1'b1;
         S_ST_WAIT: begin
            cw.mov = 1'b1;
            cw.rw  = 1'b0;
         end
         S_BEQ:        cw.alu_op = ALU_SUB;
         S_BR_TAKEN: begin
            cw.pc_ld  = 1'b1;
            cw.npc_ld = 1'b1;
         end
         S_LD_ADDR:    cw.mar_ld = 1'b1;
         S_LD_WAIT: begin
            cw.mov    = 1'b1;
            cw.mdr_ld = 1'b1;
         end
         S_LD_WB: begin
            cw.rf_ld  = 1'b1;
            cw.alu_op = ALU_PASS_B;
         end
         S_ILLEGAL:    cw.illegal_instr = 1'b1;
`ifdef SEQ_MOC_TIMEOUT_EN
         S_BUS_ERR:    cw.bus_err = 1'b1;
`endif
         default:      ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Multicycle MIPS control unit: state register, next-state sequencing
// (fetch / decode / execute) and the MOV/MOC memory handshake.
// Ports:
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   State_Sel [6:0]   : decode-time next state from the instruction encoder
//   MOC               : memory operation complete
//   Z                 : ALU zero flag (BEQ)
//   Current_State[6:0]: state register
//   MAR_Ld, IR_Ld, PC_Ld, NPC_Ld, RF_Ld, MDR_Ld : register load enables
//   MOV, RW           : memory valid, direction (1 = read)
//   ALU_Op [3:0]      : ALU function select
//   Illegal_Instr     : one-cycle pulse on an undecodable instruction
//   Bus_Err           : sticky bus error (0 unless timeout feature built in)
// Optional feature macro: SEQ_MOC_TIMEOUT_EN adds the MOC_TIMEOUT parameter,
// a wait-state counter and the BUS_ERR state.
// -----------------------------------------------------------------------------
module control_sequencer
   import control_pkg::*;
`ifdef SEQ_MOC_TIMEOUT_EN
   #(parameter int MOC_TIMEOUT = 15)
`endif
   (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [6:0] State_Sel,
   input  logic       MOC,
   input  logic       Z,
   output logic [6:0] Current_State,
   output logic       MAR_Ld,
   output logic       IR_Ld,
   output logic       PC_Ld,
   output logic       NPC_Ld,
   output logic       RF_Ld,
   output logic       MDR_Ld,
   output logic       MOV,
   output logic       RW,
   output logic [3:0] ALU_Op,
   output logic       Illegal_Instr,
   output logic       Bus_Err
   );

   state_t     state;
   state_t     next_state;
   ctrl_word_t cw;
   logic       timeout_hit;

`ifdef SEQ_MOC_TIMEOUT_EN
   localparam logic [5:0] TIMEOUT_LIMIT = 6'(MOC_TIMEOUT);

   logic [4:0] wait_cnt;
   logic       in_wait;

   assign in_wait = (state == S_FETCH_WAIT) || (state == S_ST_WAIT) ||
                    (state == S_LD_WAIT);

   // wait_cnt holds the cycles already spent in the wait state, so the
   // current cycle is number wait_cnt+1; the limit cycle is the one where
   // that reaches MOC_TIMEOUT.
   assign timeout_hit = in_wait && (({1'b0, wait_cnt} + 6'd1) >= TIMEOUT_LIMIT);

   // Any state change restarts the count, so every wait state is entered
   // with a fresh zero; staying in a wait state counts up and saturates.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wait_cnt <= '0;
      end else if (next_state != state) begin
         wait_cnt <= '0;
      end else if (in_wait && (wait_cnt != 5'd31)) begin
         wait_cnt <= wait_cnt + 5'd1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register; reset forces RESET immediately, which also drops the
   // Moore outputs (MOV included) without waiting for an edge.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_RESET;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. In wait states MOC is checked before the timeout so a
   // completion on the limit cycle still wins. Unknown encodings fall back
   // to RESET.
   always_comb begin
      next_state = S_RESET;
      case (state)
         S_RESET:      next_state = S_FETCH_ADDR;
         S_FETCH_ADDR: next_state = S_FETCH_WAIT;
         S_FETCH_WAIT: begin
            if (MOC)              next_state = S_IR_LOAD;
            else if (timeout_hit) next_state = S_BUS_ERR;
            else                  next_state = S_FETCH_WAIT;
         end
         S_IR_LOAD:    next_state = S_DECODE;
         S_DECODE: begin
            if (is_decodable(State_Sel)) next_state = state_t'(State_Sel);
            else                         next_state = S_ILLEGAL;
         end
         S_ADDU, S_SUBU, S_ADDIU, S_SLTU: next_state = S_FETCH_ADDR;
         S_ST_ADDR:    next_state = S_ST_DATA;
         S_ST_DATA:    next_state = S_ST_WAIT;
         S_ST_WAIT: begin
            if (MOC)              next_state = S_FETCH_ADDR;
            else if (timeout_hit) next_state = S_BUS_ERR;
            else                  next_state = S_ST_WAIT;
         end
         S_BEQ: begin
            if (Z) next_state = S_BR_TAKEN;
            else   next_state = S_FETCH_ADDR;
         end
         S_BR_TAKEN:   next_state = S_FETCH_ADDR;
         S_LD_ADDR:    next_state = S_LD_WAIT;
         S_LD_WAIT: begin
            if (MOC)              next_state = S_LD_WB;
            else if (timeout_hit) next_state = S_BUS_ERR;
            else                  next_state = S_LD_WAIT;
         end
         S_LD_WB:      next_state = S_FETCH_ADDR;
         S_ILLEGAL:    next_state = S_FETCH_ADDR;
`ifdef SEQ_MOC_TIMEOUT_EN
         S_BUS_ERR:    next_state = S_BUS_ERR;
`endif
         default:      next_state = S_RESET;
      endcase
   end

   control_rom u_rom (
      .state (state),
      .cw    (cw)
   );

   assign Current_State = state;
   assign MAR_Ld        = cw.mar_ld;
   assign IR_Ld         = cw.ir_ld;
   assign PC_Ld         = cw.pc_ld;
   assign NPC_Ld        = cw.npc_ld;
   assign RF_Ld         = cw.rf_ld;
   assign MDR_Ld        = cw.mdr_ld;
   assign MOV           = cw.mov;
   assign RW            = cw.rw;
   assign ALU_Op        = cw.alu_op;
   assign Illegal_Instr = cw.illegal_instr;
   assign Bus_Err       = cw.bus_err;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Scoreboard bench for control_sequencer. Each issued instruction pushes an
// expected per-instruction summary (cycle count and how many cycles each
// control output was active) computed from the instruction rules; a monitor
// accumulates the DUT outputs from one FETCH_ADDR to the next and compares.
// A memory model answers MOV with MOC after a chosen delay and drives random
// MOC noise outside wait states. With SEQ_MOC_TIMEOUT_EN the bus-error
// timeout is exercised with MOC_TIMEOUT = 4.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

   logic       Clk       = 1'b0;
   logic       Reset_n   = 1'b0;
   logic [6:0] State_Sel = 7'd0;
   logic       MOC       = 1'b0;
   logic       Z         = 1'b0;
   logic [6:0] Current_State;
   logic       MAR_Ld, IR_Ld, PC_Ld, NPC_Ld, RF_Ld, MDR_Ld;
   logic       MOV, RW, Illegal_Instr, Bus_Err;
   logic [3:0] ALU_Op;

   always #5 Clk = ~Clk;

`ifdef SEQ_MOC_TIMEOUT_EN
   control_sequencer #(.MOC_TIMEOUT(4)) dut (
`else
   control_sequencer dut (
`endif
      .Clk(Clk), .Reset_n(Reset_n), .State_Sel(State_Sel), .MOC(MOC), .Z(Z),
      .Current_State(Current_State), .MAR_Ld(MAR_Ld), .IR_Ld(IR_Ld),
      .PC_Ld(PC_Ld), .NPC_Ld(NPC_Ld), .RF_Ld(RF_Ld), .MDR_Ld(MDR_Ld),
      .MOV(MOV), .RW(RW), .ALU_Op(ALU_Op), .Illegal_Instr(Illegal_Instr),
      .Bus_Err(Bus_Err)
   );

   typedef struct packed {
      logic [7:0] cycles;
      logic [7:0] mar;
      logic [7:0] ir;
      logic [7:0] pc;
      logic [7:0] npc;
      logic [7:0] rf;
      logic [7:0] mdr;
      logic [7:0] mov;
      logic [7:0] nrw;
      logic [7:0] ill;
      logic [7:0] sub;
      logic [7:0] sltu;
      logic [7:0] passb;
      logic [7:0] berr;
   } summary_t;

   summary_t sb_queue[$];
   int       sel_queue[$];
   int       tests_run    = 0;
   int       tests_failed = 0;
   bit       mon_en       = 1'b0;
   int       mem_delay    = 0;
   int       mov_cycles   = 0;

   // Reference: latency and per-output activity of one instruction, from the
   // instruction-class rules. d = extra MOC wait cycles in every wait state.
   function automatic summary_t expectedSummary(input int sel, input bit z, input int d);
      summary_t s;
      int cyc, mar, pc, rf, mdr, mov, nrw, ill, sub, sltu, passb;
      cyc = 4 + d; mar = 1; pc = 1; mov = d + 1;
      rf = 0; mdr = 0; nrw = 0; ill = 0; sub = 0; sltu = 0; passb = 0;
      if (sel == 6 || sel == 17 || sel == 18 || sel == 19) begin
         cyc += 1; rf = 1;
         sub  = (sel == 17) ? 1 : 0;
         sltu = (sel == 19) ? 1 : 0;
      end else if (sel == 7) begin
         cyc += 3 + d; mar += 1; mdr = 1; mov += d + 1; nrw = d + 1;
      end else if (sel == 11) begin
         cyc += 1; sub = 1;
         if (z) begin cyc += 1; pc += 1; end
      end else if (sel == 13) begin
         cyc += 3 + d; mar += 1; mdr = d + 1; mov += d + 1; rf = 1; passb = 1;
      end else begin
         cyc += 1; ill = 1;
      end
      s.cycles = 8'(cyc); s.mar = 8'(mar); s.ir = 8'd1; s.pc = 8'(pc);
      s.npc = 8'(pc); s.rf = 8'(rf); s.mdr = 8'(mdr); s.mov = 8'(mov);
      s.nrw = 8'(nrw); s.ill = 8'(ill); s.sub = 8'(sub); s.sltu = 8'(sltu);
      s.passb = 8'(passb); s.berr = 8'd0;
      return s;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
      tests_run++;
      if (actual !== required) begin
         tests_failed++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic checkOutput(input summary_t got);
      summary_t exp;
      int       sel;
      tests_run++;
      if (sb_queue.size() == 0) begin
         tests_failed++;
         $display("[TB] FAIL instr_unexpected actual=%h required=none", got);
      end else begin
         exp = sb_queue.pop_front();
         sel = sel_queue.pop_front();
         if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL instr_summary sel=%0d actual=%h required=%h", sel, got, exp);
         end
      end
   endtask

   // Memory model: answers the (mem_delay+1)-th cycle of a MOV burst with
   // MOC; outside bursts MOC is random noise that must be ignored.
   always @(negedge Clk) begin
      if (MOV) begin
         mov_cycles = mov_cycles + 1;
         MOC = (mov_cycles == mem_delay + 1);
      end else begin
         mov_cycles = 0;
         MOC = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: an instruction spans FETCH_ADDR up to the next FETCH_ADDR.
   summary_t acc;
   bit       in_prog = 1'b0;
   always @(negedge Clk) begin
      if (!mon_en || !Reset_n) begin
         in_prog = 1'b0;
      end else begin
         if (Current_State == 7'd1) begin
            if (in_prog) checkOutput(acc);
            acc = '0;
            in_prog = 1'b1;
         end
         if (in_prog) begin
            acc.cycles = acc.cycles + 8'd1;
            acc.mar    = acc.mar   + 8'(MAR_Ld);
            acc.ir     = acc.ir    + 8'(IR_Ld);
            acc.pc     = acc.pc    + 8'(PC_Ld);
            acc.npc    = acc.npc   + 8'(NPC_Ld);
            acc.rf     = acc.rf    + 8'(RF_Ld);
            acc.mdr    = acc.mdr   + 8'(MDR_Ld);
            acc.mov    = acc.mov   + 8'(MOV);
            acc.nrw    = acc.nrw   + 8'(!RW);
            acc.ill    = acc.ill   + 8'(Illegal_Instr);
            acc.sub    = acc.sub   + 8'(ALU_Op == 4'd1);
            acc.sltu   = acc.sltu  + 8'(ALU_Op == 4'd2);
            acc.passb  = acc.passb + 8'(ALU_Op == 4'd3);
            acc.berr   = acc.berr  + 8'(Bus_Err);
         end
      end
   end

   // Called at a falling edge; returns at the first falling edge (possibly
   // the current one) where the DUT is in the target state.
   task automatic waitForState(input logic [6:0] target, input int budget, input string name);
      int n;
      n = 0;
      while (Current_State !== target && n < budget) begin
         @(negedge Clk);
         n++;
      end
      if (Current_State !== target) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL %s_timeout actual=%0d required=%0d", name, Current_State, target);
      end
   endtask

   task automatic applyStimulus(input int sel, input bit z, input int d);
      waitForState(7'd1, 100, "fetch");
      State_Sel = 7'(sel);
      Z         = z;
      mem_delay = d;
      sb_queue.push_back(expectedSummary(sel, z, d));
      sel_queue.push_back(sel);
      @(negedge Clk);
   endtask

   task automatic randomInstr();
      int legal[7] = '{6, 7, 11, 13, 17, 18, 19};
      int sel;
      if ($urandom_range(0, 4) == 0) sel = $urandom_range(0, 127);
      else                           sel = legal[$urandom_range(0, 6)];
      applyStimulus(sel, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
   endtask

   // Let the last issued instruction complete, then stop the monitor.
   task automatic drain(input string name);
      waitForState(7'd1, 100, "drain");
      @(negedge Clk);
      mon_en = 1'b0;
      @(negedge Clk);
      checkValue(name, sb_queue.size(), 0);
      sb_queue.delete();
      sel_queue.delete();
   endtask

   task automatic resetPulse();
      @(negedge Clk);
      Reset_n = 1'b0;
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      int wait_cyc;
      repeat (2) @(negedge Clk);
      checkValue("reset_state", Current_State, 0);
      checkValue("reset_outputs", {MAR_Ld, IR_Ld, PC_Ld, NPC_Ld, RF_Ld, MDR_Ld, MOV, RW,
                                   ALU_Op, Illegal_Instr, Bus_Err}, 0);
      mon_en  = 1'b1;
      Reset_n = 1'b1;
      @(negedge Clk);
      checkValue("first_fetch", Current_State, 1);

      applyStimulus(6, 1'b0, 0);
      applyStimulus(11, 1'b1, 0);
      applyStimulus(11, 1'b0, 0);
      applyStimulus(13, 1'b0, 3);
      applyStimulus(0, 1'b0, 0);
      applyStimulus(7, 1'b0, 0);
      applyStimulus(7, 1'b1, 2);
      applyStimulus(17, 1'b0, 1);
      applyStimulus(19, 1'b0, 0);
      applyStimulus(18, 1'b1, 0);
      applyStimulus(127, 1'b1, 1);
      for (int i = 0; i < 40; i++) randomInstr();
      drain("drain_first");

      // Abort a store while it waits for memory.
      waitForState(7'd1, 100, "fetch");
      State_Sel = 7'd7;
      mem_delay = 6;
      @(negedge Clk);
      waitForState(7'd9, 50, "store_wait");
      #2 Reset_n = 1'b0;
      #1;
      checkValue("abort_state", Current_State, 0);
      checkValue("abort_mov", MOV, 0);
      @(negedge Clk);
      mon_en  = 1'b1;
      Reset_n = 1'b1;
      @(negedge Clk);
      checkValue("restart_fetch", Current_State, 1);
      for (int i = 0; i < 20; i++) randomInstr();
      drain("drain_second");

`ifdef SEQ_MOC_TIMEOUT_EN
      // MOC never arrives: four fetch-wait cycles, then sticky bus error.
      mem_delay = 1000;
      resetPulse();
      wait_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (Current_State == 7'd2) wait_cyc++;
         if (Current_State == 7'd5 || Current_State == 7'd3) break;
      end
      checkValue("timeout_cycles", wait_cyc, 4);
      checkValue("timeout_state", Current_State, 5);
      repeat (5) @(negedge Clk);
      checkValue("bus_err_sticky", {Current_State, Bus_Err}, {7'd5, 1'b1});

      // MOC on the limit cycle wins over the timeout.
      mem_delay = 3;
      resetPulse();
      wait_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (Current_State == 7'd2) wait_cyc++;
         if (Current_State == 7'd5 || Current_State == 7'd3) break;
      end
      checkValue("limit_moc_cycles", wait_cyc, 4);
      checkValue("limit_moc_state", Current_State, 3);
      checkValue("limit_moc_bus_err", Bus_Err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
